// File: rtl/hpu_pkg.sv
// Shared rename-stage sizes, index types and the SRAT request/response bundles.
// Holds no logic, only types and constants for the ID pipeline.
package hpu_pkg;

  localparam int unsigned INST_DEC_PARAL = 2;
  localparam int unsigned ARC_SR_LEN     = 32;
  localparam int unsigned PHY_SR_LEN     = 64;

  typedef logic [$clog2(ARC_SR_LEN)-1:0] arc_sr_index_t;
  typedef logic [$clog2(PHY_SR_LEN)-1:0] phy_sr_index_t;

  typedef enum logic {
    SRAT_IDLE = 1'b0,
    SRAT_RCOV = 1'b1
  } srat_state_e;

  typedef struct packed {
    logic                                en;
    logic          [INST_DEC_PARAL-1:0]  avail;
    arc_sr_index_t [INST_DEC_PARAL-1:0]  rs1;
    arc_sr_index_t [INST_DEC_PARAL-1:0]  rs2;
    logic          [INST_DEC_PARAL-1:0]  rdst_en;
    arc_sr_index_t [INST_DEC_PARAL-1:0]  arc_rdst;
    phy_sr_index_t [INST_DEC_PARAL-1:0]  phy_rdst;
  } ren_req_t;

  typedef struct packed {
    phy_sr_index_t [INST_DEC_PARAL-1:0]  phy_rs1;
    phy_sr_index_t [INST_DEC_PARAL-1:0]  phy_rs2;
    phy_sr_index_t [INST_DEC_PARAL-1:0]  phy_old_rdst;
  } ren_rsp_t;

endpackage

// File: rtl/hpu_ren_srat_byp.sv
// Per-slot intra-group bypass: youngest older slot writing the looked-up arch reg wins over the table.
// Purely combinational, zero latency, no backpressure.
module hpu_ren_srat_byp #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 6
) (
  input  logic [N-1:0][AW-1:0] key_i,
  input  logic [N-1:0][DW-1:0] tbl_i,
  input  logic [N-1:0]         wr_en_i,
  input  logic [N-1:0][AW-1:0] wr_arc_i,
  input  logic [N-1:0][DW-1:0] wr_phy_i,
  output logic [N-1:0][DW-1:0] res_o
);

  // The last slot only ever acts as a reader here.
  logic unused_last_slot;
  assign unused_last_slot = ^{wr_en_i[N-1], wr_arc_i[N-1], wr_phy_i[N-1]};

  always_comb begin
    res_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      res_o[i] = tbl_i[i];
      for (int j = 0; j < i; j++) begin
        if (wr_en_i[j] && (wr_arc_i[j] == key_i[i])) begin
          res_o[i] = wr_phy_i[j];
        end
      end
    end
  end

endmodule

// File: rtl/hpu_ren_srat.sv
// Speculative RAT: combinational rename lookups with intra-group bypass, writes visible next cycle.
// ren_rdy_o drops in the flush cycle and the following one; the table reloads from the ARAT at that edge.
module hpu_ren_srat #(
  parameter int unsigned INST_DEC_PARAL = hpu_pkg::INST_DEC_PARAL,
  parameter int unsigned ARC_SR_LEN     = hpu_pkg::ARC_SR_LEN,
  parameter int unsigned PHY_SR_LEN     = hpu_pkg::PHY_SR_LEN
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          ren_en_i,
  input  logic                  [INST_DEC_PARAL-1:0]    ren_avail_i,
  input  hpu_pkg::arc_sr_index_t [INST_DEC_PARAL-1:0]   arc_rs1_index_i,
  input  hpu_pkg::arc_sr_index_t [INST_DEC_PARAL-1:0]   arc_rs2_index_i,
  input  logic                  [INST_DEC_PARAL-1:0]    rdst_en_i,
  input  hpu_pkg::arc_sr_index_t [INST_DEC_PARAL-1:0]   arc_rdst_index_i,
  input  hpu_pkg::phy_sr_index_t [INST_DEC_PARAL-1:0]   phy_rdst_index_i,
  output logic                                          ren_rdy_o,
  output hpu_pkg::phy_sr_index_t [INST_DEC_PARAL-1:0]   phy_rs1_index_o,
  output hpu_pkg::phy_sr_index_t [INST_DEC_PARAL-1:0]   phy_rs2_index_o,
  output hpu_pkg::phy_sr_index_t [INST_DEC_PARAL-1:0]   phy_old_rdst_index_o,
  input  logic                                          arat_rcov_en_i,
  input  hpu_pkg::phy_sr_index_t [ARC_SR_LEN-1:0]       arat_rcov_data_i
);

  import hpu_pkg::*;

  localparam int unsigned ARC_W = $clog2(ARC_SR_LEN);
  localparam int unsigned PHY_W = $clog2(PHY_SR_LEN);

  ren_req_t                            req;
  ren_rsp_t                            rsp;
  srat_state_e                         state_q, state_d;
  phy_sr_index_t [ARC_SR_LEN-1:0]      tbl_q, tbl_d;
  logic                                fire;
  logic                                rcov_load;
  logic          [INST_DEC_PARAL-1:0]  wr_en;
  phy_sr_index_t [INST_DEC_PARAL-1:0]  rs1_tbl, rs2_tbl, old_tbl;

  always_comb begin
    req          = '0;
    req.en       = ren_en_i;
    req.avail    = ren_avail_i;
    req.rs1      = arc_rs1_index_i;
    req.rs2      = arc_rs2_index_i;
    req.rdst_en  = rdst_en_i;
    req.arc_rdst = arc_rdst_index_i;
    req.phy_rdst = phy_rdst_index_i;
  end

  assign ren_rdy_o = (state_q == SRAT_IDLE) && !arat_rcov_en_i;
  assign fire      = req.en && ren_rdy_o;
  assign wr_en     = req.avail & req.rdst_en;

  // The copy waits one cycle so commits landing in the ARAT on the flush edge are included.
  always_comb begin
    state_d   = state_q;
    rcov_load = 1'b0;
    case (state_q)
      SRAT_IDLE: begin
        if (arat_rcov_en_i) begin
          state_d = SRAT_RCOV;
        end
      end
      SRAT_RCOV: begin
        if (!arat_rcov_en_i) begin
          state_d   = SRAT_IDLE;
          rcov_load = 1'b1;
        end
      end
      default: state_d = SRAT_IDLE;
    endcase
  end

  // Later slots overwrite earlier ones, so the highest slot wins on a shared arch reg.
  always_comb begin
    tbl_d = tbl_q;
    if (rcov_load) begin
      tbl_d = arat_rcov_data_i;
    end else if (fire) begin
      for (int i = 0; i < int'(INST_DEC_PARAL); i++) begin
        if (wr_en[i]) begin
          tbl_d[req.arc_rdst[i]] = req.phy_rdst[i];
        end
      end
    end
  end

  always_comb begin
    rs1_tbl = '0;
    rs2_tbl = '0;
    old_tbl = '0;
    for (int i = 0; i < int'(INST_DEC_PARAL); i++) begin
      rs1_tbl[i] = tbl_q[req.rs1[i]];
      rs2_tbl[i] = tbl_q[req.rs2[i]];
      old_tbl[i] = tbl_q[req.arc_rdst[i]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= SRAT_IDLE;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
    end
  end

  hpu_ren_srat_byp #(.N(INST_DEC_PARAL), .AW(ARC_W), .DW(PHY_W)) u_byp_rs1 (
    .key_i    (req.rs1),
    .tbl_i    (rs1_tbl),
    .wr_en_i  (wr_en),
    .wr_arc_i (req.arc_rdst),
    .wr_phy_i (req.phy_rdst),
    .res_o    (rsp.phy_rs1)
  );

  hpu_ren_srat_byp #(.N(INST_DEC_PARAL), .AW(ARC_W), .DW(PHY_W)) u_byp_rs2 (
    .key_i    (req.rs2),
    .tbl_i    (rs2_tbl),
    .wr_en_i  (wr_en),
    .wr_arc_i (req.arc_rdst),
    .wr_phy_i (req.phy_rdst),
    .res_o    (rsp.phy_rs2)
  );

  hpu_ren_srat_byp #(.N(INST_DEC_PARAL), .AW(ARC_W), .DW(PHY_W)) u_byp_old (
    .key_i    (req.arc_rdst),
    .tbl_i    (old_tbl),
    .wr_en_i  (wr_en),
    .wr_arc_i (req.arc_rdst),
    .wr_phy_i (req.phy_rdst),
    .res_o    (rsp.phy_old_rdst)
  );

  assign phy_rs1_index_o      = rsp.phy_rs1;
  assign phy_rs2_index_o      = rsp.phy_rs2;
  assign phy_old_rdst_index_o = rsp.phy_old_rdst;

endmodule

// File: tb/tb_hpu_ren_srat.sv
// Bench for hpu_ren_srat: directed rename/flush/reset cases then random traffic against an array model.
module tb_hpu_ren_srat;
  import hpu_pkg::*;

  localparam int N = INST_DEC_PARAL;

  logic                           clk_i = 1'b0;
  logic                           rst_i = 1'b0;
  logic                           ren_en_i;
  logic          [N-1:0]          ren_avail_i;
  arc_sr_index_t [N-1:0]          arc_rs1_index_i, arc_rs2_index_i, arc_rdst_index_i;
  logic          [N-1:0]          rdst_en_i;
  phy_sr_index_t [N-1:0]          phy_rdst_index_i;
  logic                           ren_rdy_o;
  phy_sr_index_t [N-1:0]          phy_rs1_index_o, phy_rs2_index_o, phy_old_rdst_index_o;
  logic                           arat_rcov_en_i;
  phy_sr_index_t [ARC_SR_LEN-1:0] arat_rcov_data_i;

  int total = 0;
  int bad   = 0;

  int m_tbl [ARC_SR_LEN];
  bit m_pend;

  always #5 clk_i = ~clk_i;

  hpu_ren_srat dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .ren_en_i             (ren_en_i),
    .ren_avail_i          (ren_avail_i),
    .arc_rs1_index_i      (arc_rs1_index_i),
    .arc_rs2_index_i      (arc_rs2_index_i),
    .rdst_en_i            (rdst_en_i),
    .arc_rdst_index_i     (arc_rdst_index_i),
    .phy_rdst_index_i     (phy_rdst_index_i),
    .ren_rdy_o            (ren_rdy_o),
    .phy_rs1_index_o      (phy_rs1_index_o),
    .phy_rs2_index_o      (phy_rs2_index_o),
    .phy_old_rdst_index_o (phy_old_rdst_index_o),
    .arat_rcov_en_i       (arat_rcov_en_i),
    .arat_rcov_data_i     (arat_rcov_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < ARC_SR_LEN; k++) m_tbl[k] = 0;
    m_pend = 1'b0;
  endfunction

  // Rename result for a key seen by a slot: nearest older writer in the group, else the table.
  function automatic int m_look(int slot, int key);
    int r;
    r = m_tbl[key];
    for (int j = slot - 1; j >= 0; j--) begin
      if (ren_avail_i[j] && rdst_en_i[j] && int'(arc_rdst_index_i[j]) == key) begin
        r = int'(phy_rdst_index_i[j]);
        break;
      end
    end
    return r;
  endfunction

  task automatic clear();
    ren_en_i         = 1'b0;
    ren_avail_i      = '0;
    rdst_en_i        = '0;
    arc_rs1_index_i  = '0;
    arc_rs2_index_i  = '0;
    arc_rdst_index_i = '0;
    phy_rdst_index_i = '0;
    arat_rcov_en_i   = 1'b0;
    for (int k = 0; k < ARC_SR_LEN; k++) arat_rcov_data_i[k] = phy_sr_index_t'($urandom_range(0, 63));
  endtask

  task automatic check_outputs(input string tag);
    bit rdy;
    rdy = !m_pend && !arat_rcov_en_i;
    chk({tag, ".rdy"}, {31'b0, ren_rdy_o}, {31'b0, rdy});
    if (rdy && ren_en_i) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s.rs1[%0d]", tag, i), 32'(phy_rs1_index_o[i]), m_look(i, int'(arc_rs1_index_i[i])));
        chk($sformatf("%s.rs2[%0d]", tag, i), 32'(phy_rs2_index_o[i]), m_look(i, int'(arc_rs2_index_i[i])));
        chk($sformatf("%s.old[%0d]", tag, i), 32'(phy_old_rdst_index_o[i]), m_look(i, int'(arc_rdst_index_i[i])));
      end
    end
  endtask

  task automatic clock_edge();
    bit rdy;
    rdy = !m_pend && !arat_rcov_en_i;
    @(posedge clk_i);
    if (arat_rcov_en_i) begin
      m_pend = 1'b1;
    end else if (m_pend) begin
      for (int k = 0; k < ARC_SR_LEN; k++) m_tbl[k] = int'(arat_rcov_data_i[k]);
      m_pend = 1'b0;
    end else if (rdy && ren_en_i) begin
      for (int i = 0; i < N; i++)
        if (ren_avail_i[i] && rdst_en_i[i]) m_tbl[arc_rdst_index_i[i]] = int'(phy_rdst_index_i[i]);
    end
    @(negedge clk_i);
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    clock_edge();
  endtask

  initial begin
    int key;
    clear();
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Reset state
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; arc_rs1_index_i[0] = 5;
    #1;
    chk("reset.rs1_0", 32'(phy_rs1_index_o[0]), 0);
    step("reset");

    // Rename and same-cycle bypass
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b11; rdst_en_i = 2'b01;
    arc_rdst_index_i[0] = 3; phy_rdst_index_i[0] = 40; arc_rs1_index_i[1] = 3;
    #1;
    chk("ren.byp_rs1_1", 32'(phy_rs1_index_o[1]), 40);
    chk("ren.old_0", 32'(phy_old_rdst_index_o[0]), 0);
    step("ren");
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; arc_rs1_index_i[0] = 3;
    #1;
    chk("vis.rs1_0", 32'(phy_rs1_index_o[0]), 40);
    step("vis");

    // Same arch destination in both slots
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b11; rdst_en_i = 2'b11;
    arc_rdst_index_i[0] = 7; arc_rdst_index_i[1] = 7; phy_rdst_index_i[0] = 10; phy_rdst_index_i[1] = 11;
    #1;
    chk("conf.old_1", 32'(phy_old_rdst_index_o[1]), 10);
    step("conf");
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; arc_rs2_index_i[0] = 7;
    #1;
    chk("conf.next_r7", 32'(phy_rs2_index_o[0]), 11);
    step("conf_next");

    // Single flush with a rename attempt in F and F+1
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; rdst_en_i = 2'b01;
    arc_rdst_index_i[0] = 3; phy_rdst_index_i[0] = 50; arat_rcov_en_i = 1'b1;
    #1;
    chk("flush.F_rdy", {31'b0, ren_rdy_o}, 0);
    step("flush_F");
    arat_rcov_en_i = 1'b0; arat_rcov_data_i[3] = 22;
    #1;
    chk("flush.F1_rdy", {31'b0, ren_rdy_o}, 0);
    step("flush_F1");
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; arc_rs1_index_i[0] = 3;
    #1;
    chk("flush.F2_rdy", {31'b0, ren_rdy_o}, 1);
    chk("flush.F2_r3", 32'(phy_rs1_index_o[0]), 22);
    step("flush_F2");

    // Back-to-back flush
    clear(); arat_rcov_en_i = 1'b1; step("dbl_F");
    clear(); arat_rcov_en_i = 1'b1; step("dbl_F1");
    clear(); arat_rcov_data_i[9] = 33;
    #1;
    chk("dbl.F2_rdy", {31'b0, ren_rdy_o}, 0);
    step("dbl_F2");
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b01; arc_rs1_index_i[0] = 9;
    #1;
    chk("dbl.F3_r9", 32'(phy_rs1_index_o[0]), 33);
    step("dbl_F3");

    // Random traffic, narrow arch range to force collisions
    for (int c = 0; c < 400; c++) begin
      clear();
      ren_en_i       = ($urandom_range(0, 7) != 0);
      ren_avail_i    = N'($urandom);
      rdst_en_i      = N'($urandom);
      arat_rcov_en_i = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < N; i++) begin
        arc_rs1_index_i[i]  = arc_sr_index_t'($urandom_range(0, 7));
        arc_rs2_index_i[i]  = arc_sr_index_t'($urandom_range(0, 7));
        arc_rdst_index_i[i] = arc_sr_index_t'($urandom_range(0, 7));
        phy_rdst_index_i[i] = phy_sr_index_t'($urandom_range(0, 63));
      end
      step("rnd");
    end

    // Asynchronous reset in the middle of recovery
    clear(); arat_rcov_en_i = 1'b1; step("ar_F");
    key = 1;
    for (int k = 1; k < ARC_SR_LEN; k++) if (m_tbl[k] != 0) key = k;
    clear(); ren_en_i = 1'b1; ren_avail_i = 2'b11; arc_rs1_index_i[0] = arc_sr_index_t'(key);
    arc_rs2_index_i[1] = arc_sr_index_t'(key);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("ar.rdy_in_reset", {31'b0, ren_rdy_o}, 1);
    chk("ar.rs1_0_zero", 32'(phy_rs1_index_o[0]), 0);
    chk("ar.rs2_1_zero", 32'(phy_rs2_index_o[1]), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("ar.rdy_after", {31'b0, ren_rdy_o}, 1);
    chk("ar.rs1_after", 32'(phy_rs1_index_o[0]), 0);
    step("ar_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
